// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the butterfly datapath: default Q format,
// rounding-mode encodings and saturation bound helpers.
package fixed_pkg;

    localparam int unsigned INT_BITS_DEF  = 19;
    localparam int unsigned FRAC_BITS_DEF = 18;

    // Widest word the bound helpers can describe.
    localparam int unsigned FIXED_MAX_W = 128;

    localparam logic ROUND_TRUNC   = 1'b0;
    localparam logic ROUND_HALF_UP = 1'b1;

    // Largest positive value of a w-bit two's-complement word, zero-extended;
    // callers truncate the result to their own word width.
    function automatic logic [FIXED_MAX_W-1:0] fixed_max(input int unsigned w);
        return (FIXED_MAX_W'(1) << (w - 1)) - FIXED_MAX_W'(1);
    endfunction

    // Most negative value of a w-bit word; only the low w bits are meaningful.
    function automatic logic [FIXED_MAX_W-1:0] fixed_min(input int unsigned w);
        return FIXED_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// Combinational round / shift / saturate of a double-width Q product back to the
// single-width Q format. Shared with the butterfly adder.
module fixed_round_sat
    import fixed_pkg::*;
#(
    parameter int unsigned  INT_BITS  = INT_BITS_DEF,
    parameter int unsigned  FRAC_BITS = FRAC_BITS_DEF,
    parameter bit           SATURATE  = 1'b1,
    localparam int unsigned W         = INT_BITS + FRAC_BITS
) (
    input  logic [2*W-1:0] p,
    input  logic           round_mode,
    output logic [W-1:0]   c,
    output logic           ovf
);

    localparam int unsigned PW = 2 * W;
    localparam logic [W-1:0] MAX_C = W'(fixed_max(W));
    localparam logic [W-1:0] MIN_C = W'(fixed_min(W));

    logic [PW:0]    half;
    logic [PW:0]    p_rnd;
    logic [PW:0]    r;
    logic [PW-W+1:0] r_hi;

    always_comb begin
        half = '0;
        if (round_mode == ROUND_HALF_UP) begin
            half[FRAC_BITS-1] = 1'b1;
        end
        // One guard bit above the product so the half-ulp add can never wrap.
        p_rnd = {p[PW-1], p} + half;
        r     = $signed(p_rnd) >>> FRAC_BITS;
        // In range iff every bit from the W-bit sign position upward agrees.
        r_hi  = r[PW:W-1];
        ovf   = !((&r_hi) || !(|r_hi));
        if (ovf && SATURATE) begin
            c = r[PW] ? MIN_C : MAX_C;
        end else begin
            c = r[W-1:0];
        end
    end

endmodule

// File: rtl/fixed_mult_pipe.sv
// Three-stage pipelined signed Q-format multiplier with valid/ready handshake;
// a stalled output freezes the whole pipeline.
module fixed_mult_pipe
    import fixed_pkg::*;
#(
    parameter int unsigned  INT_BITS  = INT_BITS_DEF,
    parameter int unsigned  FRAC_BITS = FRAC_BITS_DEF,
    parameter bit           SATURATE  = 1'b1,
    localparam int unsigned W         = INT_BITS + FRAC_BITS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         round_mode,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] c,
    output logic         ovf
);

    logic                  stall;
    logic                  s1_valid_q, s2_valid_q, s3_valid_q;
    logic                  s1_mode_q, s2_mode_q;
    logic [W-1:0]          a_q, b_q;
    logic signed [2*W-1:0] a_ext, b_ext, p_d;
    logic [2*W-1:0]        p_q;
    logic [W-1:0]          c_d, c_q;
    logic                  ovf_d, ovf_q;

    assign stall    = s3_valid_q && !out_ready;
    assign in_ready = !stall;

    // Sign-extend to full width so the truncated product is the exact 2W-bit result.
    assign a_ext = {{W{a_q[W-1]}}, a_q};
    assign b_ext = {{W{b_q[W-1]}}, b_q};
    assign p_d   = a_ext * b_ext;

    fixed_round_sat #(
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS),
        .SATURATE  (SATURATE)
    ) u_round_sat (
        .p          (p_q),
        .round_mode (s2_mode_q),
        .c          (c_d),
        .ovf        (ovf_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_mode_q  <= 1'b0;
            s2_mode_q  <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            c_q        <= '0;
            ovf_q      <= 1'b0;
        end else if (!stall) begin
            s1_valid_q <= in_valid;
            s1_mode_q  <= round_mode;
            a_q        <= a;
            b_q        <= b;
            s2_valid_q <= s1_valid_q;
            s2_mode_q  <= s1_mode_q;
            p_q        <= p_d;
            s3_valid_q <= s2_valid_q;
            c_q        <= c_d;
            ovf_q      <= ovf_d;
        end
    end

    assign out_valid = s3_valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Directed bench for fixed_mult_pipe: saturating and wrapping instances share
// stimulus; results are checked against hand-computed Q19.18 values.
module tb_fixed_mult_pipe;

    localparam int unsigned W = 37;

    localparam logic [W-1:0] A45      = 37'h00_0012_0000;  //  4.5
    localparam logic [W-1:0] B25      = 37'h00_000A_0000;  //  2.5
    localparam logic [W-1:0] C1125    = 37'h00_002D_0000;  //  11.25
    localparam logic [W-1:0] BN55     = 37'h1F_FFEA_0000;  // -5.5
    localparam logic [W-1:0] CN2475   = 37'h1F_FF9D_0000;  // -24.75
    localparam logic [W-1:0] HALF     = 37'h00_0002_0000;  //  0.5
    localparam logic [W-1:0] ULP      = 37'h00_0000_0001;
    localparam logic [W-1:0] NEG_ULP  = 37'h1F_FFFF_FFFF;
    localparam logic [W-1:0] K1000    = 37'h00_0FA0_0000;  //  1000.0
    localparam logic [W-1:0] MAXV     = 37'h0F_FFFF_FFFF;
    localparam logic [W-1:0] MINV     = 37'h10_0000_0000;
    localparam logic [W-1:0] WRAP1000 = 37'h1D_0900_0000;  // low 37 bits of 1e6*2^18
    localparam logic [W-1:0] ZERO     = 37'h0;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         round_mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b1;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         in_ready, out_valid, ovf;
    logic [W-1:0] c;
    logic         in_ready_w, out_valid_w, ovf_w;
    logic [W-1:0] c_w;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] st_a [6];
    logic [W-1:0] st_b [6];
    logic [W-1:0] st_c [6];

    always #5 clk = ~clk;

    fixed_mult_pipe #(.INT_BITS(19), .FRAC_BITS(18), .SATURATE(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .round_mode (round_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .c          (c),
        .ovf        (ovf)
    );

    fixed_mult_pipe #(.INT_BITS(19), .FRAC_BITS(18), .SATURATE(1'b0)) dut_wrap (
        .clk        (clk),
        .rst        (rst),
        .round_mode (round_mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready_w),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid_w),
        .out_ready  (out_ready),
        .c          (c_w),
        .ovf        (ovf_w)
    );

    task automatic check_word(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated transaction; operands are scrubbed right after the transfer edge.
    task automatic run_one(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           input logic mode, input logic [W-1:0] exp_c, input logic exp_ovf,
                           input logic [W-1:0] exp_cw, input logic exp_ovfw);
        a = ta;
        b = tb_v;
        round_mode = mode;
        in_valid = 1'b1;
        check_bit({tag, ".in_ready"}, in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        a = '0;
        b = '0;
        round_mode = 1'b0;
        step();
        check_bit({tag, ".early_valid"}, out_valid, 1'b0);
        step();
        check_bit({tag, ".out_valid"}, out_valid, 1'b1);
        check_word({tag, ".c_sat"}, c, exp_c);
        check_bit({tag, ".ovf_sat"}, ovf, exp_ovf);
        check_word({tag, ".c_wrap"}, c_w, exp_cw);
        check_bit({tag, ".ovf_wrap"}, ovf_w, exp_ovfw);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        int hold;
        bit seen;

        st_a[0] = 37'h00_0004_0000; st_b[0] = 37'h00_0008_0000; st_c[0] = 37'h00_0008_0000;
        st_a[1] = 37'h00_000C_0000; st_b[1] = 37'h1F_FFFC_0000; st_c[1] = 37'h1F_FFF4_0000;
        st_a[2] = 37'h00_0002_0000; st_b[2] = 37'h00_0002_0000; st_c[2] = 37'h00_0001_0000;
        st_a[3] = 37'h00_001C_0000; st_b[3] = 37'h00_000C_0000; st_c[3] = 37'h00_0054_0000;
        st_a[4] = 37'h1F_FFF8_0000; st_b[4] = 37'h1F_FFF6_0000; st_c[4] = 37'h00_0014_0000;
        st_a[5] = 37'h00_0028_0000; st_b[5] = 37'h00_0001_0000; st_c[5] = 37'h00_000A_0000;

        // Reset state
        #2 rst = 1'b1;
        #1;
        check_bit("reset.out_valid", out_valid, 1'b0);
        check_bit("reset.out_valid_wrap", out_valid_w, 1'b0);
        check_bit("reset.in_ready", in_ready, 1'b1);
        check_word("reset.c", c, ZERO);
        check_bit("reset.ovf", ovf, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        step();
        check_bit("post_reset.out_valid", out_valid, 1'b0);
        check_bit("post_reset.in_ready", in_ready, 1'b1);

        // Directed arithmetic
        run_one("pos", A45, B25, 1'b0, C1125, 1'b0, C1125, 1'b0);
        run_one("signed", A45, BN55, 1'b0, CN2475, 1'b0, CN2475, 1'b0);
        run_one("trunc_ulp", ULP, HALF, 1'b0, ZERO, 1'b0, ZERO, 1'b0);
        run_one("round_ulp", ULP, HALF, 1'b1, ULP, 1'b0, ULP, 1'b0);
        run_one("round_neg_half", NEG_ULP, HALF, 1'b1, ZERO, 1'b0, ZERO, 1'b0);
        run_one("trunc_neg_half", NEG_ULP, HALF, 1'b0, NEG_ULP, 1'b0, NEG_ULP, 1'b0);
        run_one("zero_m0", ZERO, CN2475, 1'b0, ZERO, 1'b0, ZERO, 1'b0);
        run_one("zero_m1", A45, ZERO, 1'b1, ZERO, 1'b0, ZERO, 1'b0);
        run_one("ovf_1000", K1000, K1000, 1'b0, MAXV, 1'b1, WRAP1000, 1'b1);
        run_one("ovf_negbig", K1000, MINV, 1'b1, MINV, 1'b1, ZERO, 1'b1);
        run_one("ovf_minmin", MINV, MINV, 1'b0, MAXV, 1'b1, ZERO, 1'b1);

        // Back-to-back stream with 5 cycles of backpressure from the first result
        sent = 0;
        recv = 0;
        hold = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 40 && recv < 6; cyc++) begin
            if (sent < 6) begin
                in_valid = 1'b1;
                a = st_a[sent];
                b = st_b[sent];
            end else begin
                in_valid = 1'b0;
                a = '0;
                b = '0;
            end
            round_mode = 1'b0;
            if (out_valid && !seen) begin
                seen = 1'b1;
                hold = 5;
            end
            out_ready = (hold == 0);
            @(negedge clk);
            check_bit("stream.in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (recv < 6) begin
                    check_word($sformatf("stream.c%0d", recv), c, st_c[recv]);
                    check_word($sformatf("stream.cw%0d", recv), c_w, st_c[recv]);
                    check_bit($sformatf("stream.ovf%0d", recv), ovf, 1'b0);
                end
                recv++;
            end
            if (in_valid && in_ready) sent++;
            if (hold > 0) hold--;
            step();
        end
        checks++;
        assert (recv == 6 && sent == 6) else begin
            errors++;
            $error("FAIL stream.count: observed recv=%0d sent=%0d expected 6/6", recv, sent);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check_bit("stream.no_dup", out_valid, 1'b0);
            step();
        end

        // Reset with three pairs in flight
        for (int k = 0; k < 3; k++) begin
            a = st_a[k];
            b = st_b[k];
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check_bit("midrst.pre_valid", out_valid, 1'b1);
        #1 rst = 1'b1;
        #1;
        check_bit("midrst.out_valid", out_valid, 1'b0);
        check_word("midrst.c", c, ZERO);
        check_bit("midrst.ovf", ovf, 1'b0);
        @(posedge clk);
        #2 rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            check_bit("midrst.no_stale", out_valid, 1'b0);
        end
        run_one("after_rst", A45, B25, 1'b0, C1125, 1'b0, C1125, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
